quad_decoder: RTL and testbench
===============================

// Module: quad_decoder
// PURPOSE
//  Quadrature (A/B) decoder feeding a position count; the input-side counterpart of up_down.
//  Synchronizes asynchronous encoder phases, decodes Gray-code transitions into +1/-1 steps,
//  and maintains an N-bit wrapping position count with direction, step and error reporting.
//  Sits between off-chip encoder pins and the control logic that consumes position.
// PARAMETERS
//  N           4   width of count (modulo 2**N)
//  DIR_INVERT  0   1 = swap meaning of forward/reverse (count and dir both inverted)
// PORTS
//  clk          input   1  single clock; all logic on rising edge
//  reset        input   1  synchronous, active-high
//  a_in         input   1  encoder phase A, asynchronous
//  b_in         input   1  encoder phase B, asynchronous
//  clr          input   1  synchronous count/error clear, one-cycle pulse
//  count        output  N  position count
//  dir          output  1  direction of last valid step (1 = forward)
//  step         output  1  one-cycle pulse per valid step
//  err_pulse    output  1  one-cycle pulse on illegal transition
//  err_flag     output  1  sticky illegal-transition flag
// BEHAVIOUR
//  - Reset (sync, high): count=0, dir=0, step=0, err_pulse=0, err_flag=0, sync regs=0, state=ST_INIT.
//  - Sync: a_in/b_in through 2-FF synchronizer (s1,s2); prev holds last s2. Decode on {s2,prev}.
//  - State machine: ST_INIT -> ST_RUN after INIT_CYCLES (3) cycles; in ST_INIT prev<=s2 each
//    cycle, no decode, no step/err. Avoids false error when pins are non-zero at reset release.
//    ST_RUN persists until reset. Reset mid-operation returns to ST_INIT with all outputs zeroed.
//  - Forward sequence {A,B}: 00->01->11->10->00 => +1, dir=1. Reverse => -1, dir=0.
//    No change => no action. Both bits change => err_pulse=1, err_flag=1, count/dir unchanged.
//  - DIR_INVERT=1: forward sequence yields -1 and dir=0 (and vice versa).
//  - Latency: pin transition sampled at edge k -> count/step/dir update at edge k+2.
//  - Arithmetic: count modulo 2**N; 2**N-1 +1 -> 0; 0 -1 -> 2**N-1. No saturation.
//  - step and err_pulse high exactly one cycle per detected transition; never both high.
//  - clr: count<=0, err_flag<=0 next edge; clr wins over a simultaneous step (count=0, step
//    still pulses, dir updates); clr with simultaneous error: err_pulse=1, err_flag=1 (new error
//    wins over clear). clr ignored in ST_INIT (outputs already zero).
// CONFIGURATION
//  QUAD_INDEX_EN defined: adds input z_in (1, async index) and output index_pulse (1).
//   z_in synchronized with the same 2-FF; rising edge of synced z in ST_RUN sets count<=0 and
//   pulses index_pulse one cycle; priority over step and clr (count=0, step/dir as decoded).
//  Not defined: z_in and index_pulse ports absent; no index logic.
// STRUCTURE
//  quad_pkg: typedef enum logic {ST_INIT, ST_RUN} quad_state_t; localparam INIT_CYCLES=3;
//   localparam SYNC_STAGES=2; function quad_step(prev,cur) returning {valid,up,err}.
//  Sub-module sync_2ff (1-bit, reset to 0), instantiated per phase (and for z under macro).
// TESTING
//  1 reset with a=b=0, 4 forward steps each held 4 cycles -> count 0,1,2,3,4; dir=1; 4 step pulses.
//  2 preload count=15 via forward steps, one more forward -> count=0; one reverse -> count=15, dir=0.
//  3 {A,B} 00->11 in one cycle -> err_pulse 1 cycle, err_flag=1 sticky, count unchanged; clr -> err_flag=0.
//  4 reset mid-run with pins at 11 -> count=0, no err_pulse after release; next 11->10 -> count=1.
//  5 clr coincident with forward step at count=7 -> count=0, step=1, dir=1.
//  6 QUAD_INDEX_EN, count=9, z rising -> count=0, index_pulse 1 cycle; macro off: ports absent, compiles.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM states, timing constants
// and the Gray-code transition classifier.
package quad_pkg;

  typedef enum logic {ST_INIT, ST_RUN} quad_state_t;

  localparam int INIT_CYCLES = 3;
  localparam int SYNC_STAGES = 2;
  localparam int INIT_W      = $clog2(INIT_CYCLES + 1);

  typedef struct packed {
    logic valid;
    logic up;
    logic err;
  } quad_step_t;

  // Position of an {A,B} pair along the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_index(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic quad_step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    quad_step_t r;
    logic [1:0] delta;
    delta   = gray_index(cur) - gray_index(prev);
    r.valid = (delta == 2'd1) || (delta == 2'd3);
    r.up    = (delta == 2'd1);
    r.err   = (delta == 2'd2);
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit synchronizer for an asynchronous input; every stage clears to 0 on reset.
module sync_2ff
  import quad_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder with wrapping position count, direction, step and error reporting.
// Optional index (Z) input that zeroes the count is enabled by defining QUAD_INDEX_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int N          = 4,
  parameter int DIR_INVERT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         clr,
`ifdef QUAD_INDEX_EN
  input  logic         z_in,
  output logic         index_pulse,
`endif
  output logic [N-1:0] count,
  output logic         dir,
  output logic         step,
  output logic         err_pulse,
  output logic         err_flag
);

  localparam logic INV = (DIR_INVERT != 0);

  logic [1:0]  pins;
  logic [1:0]  pin_sync;
  logic [1:0]  prev_reg;
  quad_step_t  dec;

  quad_state_t       state_reg, state_next;
  logic [INIT_W-1:0] init_cnt_reg, init_cnt_next;
  logic [N-1:0]      count_reg, count_next;
  logic              dir_reg, dir_next;
  logic              step_reg, step_next;
  logic              err_pulse_reg, err_pulse_next;
  logic              err_flag_reg, err_flag_next;
  logic              up;

  assign pins = {a_in, b_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_phase_sync
      sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pins[gi]),
        .q     (pin_sync[gi])
      );
    end
  endgenerate

`ifdef QUAD_INDEX_EN
  logic z_sync, z_prev_reg, z_rise;
  logic index_pulse_reg, index_pulse_next;

  sync_2ff u_sync_z (
    .clk   (clk),
    .reset (reset),
    .d     (z_in),
    .q     (z_sync)
  );

  assign z_rise      = z_sync & ~z_prev_reg;
  assign index_pulse = index_pulse_reg;
`endif

  assign dec = quad_step(prev_reg, pin_sync);
  assign up  = dec.up ^ INV;

  always_comb begin
    state_next     = state_reg;
    init_cnt_next  = init_cnt_reg;
    count_next     = count_reg;
    dir_next       = dir_reg;
    step_next      = 1'b0;
    err_pulse_next = 1'b0;
    err_flag_next  = err_flag_reg;
`ifdef QUAD_INDEX_EN
    index_pulse_next = 1'b0;
`endif
    case (state_reg)
      ST_INIT: begin
        // Let prev settle onto the synchronized pins before any decoding.
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == INIT_W'(INIT_CYCLES - 1)) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        if (dec.err) begin
          err_pulse_next = 1'b1;
          err_flag_next  = 1'b1;
        end else if (dec.valid) begin
          step_next  = 1'b1;
          dir_next   = up;
          count_next = up ? count_reg + 1'b1 : count_reg - 1'b1;
        end
        // A fresh error outranks the clear of the sticky flag.
        if (clr) begin
          count_next = '0;
          if (!dec.err) begin
            err_flag_next = 1'b0;
          end
        end
`ifdef QUAD_INDEX_EN
        if (z_rise) begin
          count_next       = '0;
          index_pulse_next = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      prev_reg      <= '0;
      count_reg     <= '0;
      dir_reg       <= 1'b0;
      step_reg      <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_flag_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      prev_reg      <= pin_sync;
      count_reg     <= count_next;
      dir_reg       <= dir_next;
      step_reg      <= step_next;
      err_pulse_reg <= err_pulse_next;
      err_flag_reg  <= err_flag_next;
    end
  end

`ifdef QUAD_INDEX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      z_prev_reg      <= 1'b0;
      index_pulse_reg <= 1'b0;
    end else begin
      z_prev_reg      <= z_sync;
      index_pulse_reg <= index_pulse_next;
    end
  end
`endif

  assign count     = count_reg;
  assign dir       = dir_reg;
  assign step      = step_reg;
  assign err_pulse = err_pulse_reg;
  assign err_flag  = err_flag_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: stimulus pushes expected step/error events,
// a monitor pops and compares whenever the DUT pulses step or err_pulse.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] count;
  logic       dir, step, err_pulse, err_flag;
`ifdef QUAD_INDEX_EN
  logic       z_in = 1'b0;
  logic       index_pulse;
`endif

  quad_decoder #(.N(4), .DIR_INVERT(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .clr       (clr),
`ifdef QUAD_INDEX_EN
    .z_in        (z_in),
    .index_pulse (index_pulse),
`endif
    .count     (count),
    .dir       (dir),
    .step      (step),
    .err_pulse (err_pulse),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [3:0] cnt;
    bit         dir;
    bit         flag;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         p = 0;
  logic [3:0] ecnt = 4'd0;
  bit         edir = 1'b0;
  bit         eflag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (!reset && (step || err_pulse)) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pulse: step=%0b err_pulse=%0b count=%0d, required no pulse",
                 step, err_pulse, count);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("txn step=%0b err=%0b count=%0d dir=%0b flag=%0b", step, err_pulse, count, dir, err_flag);
        chk("txn_step",      32'(step),      32'(!e.is_err));
        chk("txn_err_pulse", 32'(err_pulse), 32'(e.is_err));
        chk("txn_count",     32'(count),     32'(e.cnt));
        chk("txn_dir",       32'(dir),       32'(e.dir));
        chk("txn_err_flag",  32'(err_flag),  32'(e.flag));
      end
    end
  end

  task automatic push_exp(input bit is_err);
    exp_t e;
    e.is_err = is_err;
    e.cnt    = ecnt;
    e.dir    = edir;
    e.flag   = eflag;
    q.push_back(e);
  endtask

  task automatic drive_pins();
    @(posedge clk);
    #1;
    {a_in, b_in} = gray[p];
  endtask

  task automatic settle();
    for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL txn_timeout: %0d events outstanding, required 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic fwd();
    p    = (p + 1) % 4;
    ecnt = ecnt + 4'd1;
    edir = 1'b1;
    push_exp(1'b0);
    drive_pins();
    settle();
  endtask

  task automatic rev();
    p    = (p + 3) % 4;
    ecnt = ecnt - 4'd1;
    edir = 1'b0;
    push_exp(1'b0);
    drive_pins();
    settle();
  endtask

  task automatic jump_err();
    p     = (p + 2) % 4;
    eflag = 1'b1;
    push_exp(1'b1);
    drive_pins();
    settle();
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    ecnt  = 4'd0;
    eflag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // 1: reset state, then four forward steps from 00.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_dir",       32'(dir),       32'd0);
    chk("rst_step",      32'(step),      32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_flag",  32'(err_flag),  32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    repeat (4) fwd();
    @(negedge clk);
    chk("fwd4_count", 32'(count), 32'd4);
    chk("fwd4_dir",   32'(dir),   32'd1);

    // 2: wrap at 15 -> 0 and back.
    while (ecnt != 4'd15) fwd();
    fwd();
    @(negedge clk);
    chk("wrap_up_count", 32'(count), 32'd0);
    rev();
    @(negedge clk);
    chk("wrap_down_count", 32'(count), 32'd15);
    chk("wrap_down_dir",   32'(dir),   32'd0);

    // 3: both phases change at once, sticky flag, then clear.
    jump_err();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("err_sticky_flag", 32'(err_flag), 32'd1);
    chk("err_count_kept",  32'(count),    32'd15);
    pulse_clr();
    @(negedge clk);
    chk("clr_err_flag", 32'(err_flag), 32'd0);
    chk("clr_count",    32'(count),    32'd0);

    // 4: reset mid-run with pins at 11; no false error afterwards.
    while (gray[p] != 2'b11) fwd();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ecnt = 4'd0; edir = 1'b0; eflag = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (step || err_pulse) pulses++;
    end
    chk("post_rst_pulses", 32'(pulses),   32'd0);
    chk("post_rst_count",  32'(count),    32'd0);
    chk("post_rst_flag",   32'(err_flag), 32'd0);
    fwd();
    @(negedge clk);
    chk("post_rst_step_count", 32'(count), 32'd1);

    // 5: clr lands on the same edge as a forward step at count 7.
    while (ecnt != 4'd7) fwd();
    p    = (p + 1) % 4;
    ecnt = 4'd0;
    edir = 1'b1;
    push_exp(1'b0);
    drive_pins();
    @(posedge clk); #1;
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    settle();
    @(negedge clk);
    chk("clr_step_count", 32'(count), 32'd0);

`ifdef QUAD_INDEX_EN
    // 6: index rising edge zeroes the count and pulses once.
    repeat (9) fwd();
    @(negedge clk);
    chk("pre_index_count", 32'(count), 32'd9);
    @(posedge clk); #1 z_in = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (index_pulse) pulses++;
    end
    chk("index_pulses", 32'(pulses), 32'd1);
    chk("index_count",  32'(count),  32'd0);
    z_in = 1'b0;
`endif

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
